// File: rtl/usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// usb_rx_sequencer : USB FS receive packet sequencer (SYNC, NRZI, unstuff, EOP)
// Rev 1.0
// ============================================================================
module usb_rx_sequencer #(
  parameter int MAX_PKT_BITS = 8208,
  parameter int IDLE_J_BITS  = 7,
  parameter int CNT_W        = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic [1:0] line_state_in,
  input  logic       line_state_valid,
  input  logic       phase_lock,
  input  logic       eop_detected,
  output logic       rx_active,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic       pkt_done,
  output logic       rx_error,
  output logic [2:0] error_code
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [2:0] ERR_STUFF    = 3'd1;
  localparam logic [2:0] ERR_SE1      = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_LOCK     = 3'd4;
  localparam logic [2:0] ERR_EOP      = 3'd5;

  localparam int              JW      = $clog2(IDLE_J_BITS + 1);
  localparam logic [JW-1:0]   J_LAST  = JW'(IDLE_J_BITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT_BITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC     = 3'd1,
    S_ACTIVE   = 3'd2,
    S_EOP_WAIT = 3'd3,
    S_EOP_CHK  = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_idx_q, sync_idx_d;
  logic [1:0]       prev_ls_q, prev_ls_d;
  logic [2:0]       ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       se0_cnt_q, se0_cnt_d;
  logic [JW-1:0]    j_cnt_q, j_cnt_d;
  logic             rx_active_q, rx_active_d;
  logic             rx_bit_q, rx_bit_d;
  logic             rx_bit_valid_q, rx_bit_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             rx_error_q, rx_error_d;
  logic [2:0]       error_code_q, error_code_d;

  logic             err_go;
  logic [2:0]       err_code;
  logic             line_bit;
  logic [1:0]       sync_exp;

  // NRZI: no transition means a 1
  assign line_bit = (line_state_in == prev_ls_q);
  // sync_idx_q holds symbols matched so far; the next symbol is K on odd positions and at position 8
  assign sync_exp = (!sync_idx_q[0] || (sync_idx_q == 3'd7)) ? LS_K : LS_J;

  always_comb begin
    state_d        = state_q;
    sync_idx_d     = sync_idx_q;
    prev_ls_d      = prev_ls_q;
    ones_cnt_d     = ones_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    se0_cnt_d      = se0_cnt_q;
    j_cnt_d        = j_cnt_q;
    rx_active_d    = rx_active_q;
    rx_bit_d       = rx_bit_q;
    rx_bit_valid_d = 1'b0;
    pkt_done_d     = 1'b0;
    rx_error_d     = 1'b0;
    error_code_d   = error_code_q;
    err_go         = 1'b0;
    err_code       = 3'd0;

    if ((state_q != S_IDLE) && !rx_enable) begin
      state_d     = S_IDLE;
      rx_active_d = 1'b0;
    end else if (!phase_lock && (state_q == S_SYNC)) begin
      state_d = S_IDLE;
    end else if (!phase_lock && ((state_q == S_ACTIVE) || (state_q == S_EOP_WAIT) ||
                                 (state_q == S_EOP_CHK))) begin
      err_go   = 1'b1;
      err_code = ERR_LOCK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (line_state_valid && (line_state_in == LS_K) && rx_enable && phase_lock) begin
            state_d      = S_SYNC;
            sync_idx_d   = 3'd1;
            error_code_d = 3'd0;
          end
        end
        S_SYNC: begin
          if (line_state_valid) begin
            if (line_state_in != sync_exp) begin
              state_d = S_IDLE;
            end else if (sync_idx_q == 3'd7) begin
              state_d     = S_ACTIVE;
              rx_active_d = 1'b1;
              prev_ls_d   = LS_K;
              ones_cnt_d  = 3'd1;
              bit_cnt_d   = '0;
            end else begin
              sync_idx_d = sync_idx_q + 3'd1;
            end
          end
        end
        S_ACTIVE: begin
          if (line_state_valid) begin
            if (line_state_in == LS_SE0) begin
              state_d   = S_EOP_WAIT;
              se0_cnt_d = 2'd1;
            end else if (line_state_in == LS_SE1) begin
              err_go   = 1'b1;
              err_code = ERR_SE1;
            end else begin
              prev_ls_d = line_state_in;
              if (ones_cnt_q == 3'd6) begin
                if (line_bit) begin
                  err_go   = 1'b1;
                  err_code = ERR_STUFF;
                end else begin
                  ones_cnt_d = 3'd0;
                end
              end else if (bit_cnt_q == MAX_CNT) begin
                err_go   = 1'b1;
                err_code = ERR_OVERFLOW;
              end else begin
                rx_bit_d       = line_bit;
                rx_bit_valid_d = 1'b1;
                ones_cnt_d     = line_bit ? (ones_cnt_q + 3'd1) : 3'd0;
                bit_cnt_d      = bit_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        S_EOP_WAIT: begin
          if (line_state_valid) begin
            if (line_state_in == LS_SE0) begin
              if (se0_cnt_q != 2'd3) se0_cnt_d = se0_cnt_q + 2'd1;
            end else if ((line_state_in == LS_J) && (se0_cnt_q >= 2'd2)) begin
              state_d = S_EOP_CHK;
            end else begin
              err_go   = 1'b1;
              err_code = ERR_EOP;
            end
          end
        end
        S_EOP_CHK: begin
          if (eop_detected) begin
            pkt_done_d  = 1'b1;
            rx_active_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            err_go   = 1'b1;
            err_code = ERR_EOP;
          end
        end
        S_ERROR: begin
          if (line_state_valid) begin
            if (line_state_in != LS_J) begin
              j_cnt_d = '0;
            end else if (j_cnt_q == J_LAST) begin
              j_cnt_d = '0;
              state_d = S_IDLE;
            end else begin
              j_cnt_d = j_cnt_q + JW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err_go) begin
      state_d      = S_ERROR;
      rx_active_d  = 1'b0;
      rx_error_d   = 1'b1;
      error_code_d = err_code;
      j_cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sync_idx_q     <= 3'd0;
      prev_ls_q      <= LS_J;
      ones_cnt_q     <= 3'd0;
      bit_cnt_q      <= '0;
      se0_cnt_q      <= 2'd0;
      j_cnt_q        <= '0;
      rx_active_q    <= 1'b0;
      rx_bit_q       <= 1'b0;
      rx_bit_valid_q <= 1'b0;
      pkt_done_q     <= 1'b0;
      rx_error_q     <= 1'b0;
      error_code_q   <= 3'd0;
    end else begin
      state_q        <= state_d;
      sync_idx_q     <= sync_idx_d;
      prev_ls_q      <= prev_ls_d;
      ones_cnt_q     <= ones_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      se0_cnt_q      <= se0_cnt_d;
      j_cnt_q        <= j_cnt_d;
      rx_active_q    <= rx_active_d;
      rx_bit_q       <= rx_bit_d;
      rx_bit_valid_q <= rx_bit_valid_d;
      pkt_done_q     <= pkt_done_d;
      rx_error_q     <= rx_error_d;
      error_code_q   <= error_code_d;
    end
  end

  assign rx_active    = rx_active_q;
  assign rx_bit       = rx_bit_q;
  assign rx_bit_valid = rx_bit_valid_q;
  assign pkt_done     = pkt_done_q;
  assign rx_error     = rx_error_q;
  assign error_code   = error_code_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_sequencer.sv
`default_nettype none
// ============================================================================
// tb_usb_rx_sequencer : directed + random packets against a behavioural model
// Rev 1.0
// ============================================================================
module tb_usb_rx_sequencer;

  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;
  localparam int TB_MAX  = 16;
  localparam int TB_IDLE = 7;

  localparam int P_IDLE = 0, P_SYNC = 1, P_DATA = 2, P_EOPW = 3, P_EOPC = 4, P_ERR = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_enable, line_state_valid, phase_lock, eop_detected;
  logic [1:0] line_state_in;
  logic       rx_active, rx_bit, rx_bit_valid, pkt_done, rx_error;
  logic [2:0] error_code;

  usb_rx_sequencer #(.MAX_PKT_BITS(TB_MAX), .IDLE_J_BITS(TB_IDLE), .CNT_W(14)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .line_state_in(line_state_in),
    .line_state_valid(line_state_valid), .phase_lock(phase_lock), .eop_detected(eop_detected),
    .rx_active(rx_active), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .pkt_done(pkt_done), .rx_error(rx_error), .error_code(error_code)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] sync_pat [8];
  int         m_mode = P_IDLE, m_seen = 0, m_run = 0, m_nbits = 0, m_se0 = 0, m_jrun = 0;
  logic [1:0] m_prev = J;
  logic       e_active = 0, e_bit = 0, e_valid = 0, e_done = 0, e_err = 0;
  logic [2:0] e_code = 0;

  task automatic to_error(input int code);
    m_mode = P_ERR; e_active = 0; e_err = 1; e_code = 3'(code); m_jrun = 0;
  endtask

  task automatic line_event(input logic [1:0] ls);
    bit b;
    case (m_mode)
      P_IDLE: if (ls == K && rx_enable && phase_lock) begin
        m_mode = P_SYNC; m_seen = 1; e_code = 0;
      end
      P_SYNC: if (ls != sync_pat[m_seen]) m_mode = P_IDLE;
      else begin
        m_seen++;
        if (m_seen == 8) begin
          m_mode = P_DATA; e_active = 1; m_prev = K; m_run = 1; m_nbits = 0;
        end
      end
      P_DATA: if (ls == SE0) begin m_mode = P_EOPW; m_se0 = 1; end
      else if (ls == SE1) to_error(2);
      else begin
        b = (ls == m_prev);
        m_prev = ls;
        if (m_run == 6) begin
          if (b) to_error(1); else m_run = 0;
        end else if (m_nbits >= TB_MAX) to_error(3);
        else begin
          e_valid = 1; e_bit = b; m_nbits++; m_run = b ? m_run + 1 : 0;
        end
      end
      P_EOPW: if (ls == SE0) m_se0++;
      else if (ls == J && m_se0 >= 2) m_mode = P_EOPC;
      else to_error(5);
      P_ERR: if (ls == J) begin
        m_jrun++;
        if (m_jrun == TB_IDLE) m_mode = P_IDLE;
      end else m_jrun = 0;
      default: ;
    endcase
  endtask

  task automatic model_step();
    e_valid = 0; e_done = 0; e_err = 0;
    if (rst) begin
      m_mode = P_IDLE; m_prev = J; m_run = 0; m_nbits = 0; m_se0 = 0; m_jrun = 0; m_seen = 0;
      e_active = 0; e_bit = 0; e_code = 0;
    end else if (m_mode != P_IDLE && !rx_enable) begin
      m_mode = P_IDLE; e_active = 0;
    end else if (!phase_lock && m_mode == P_SYNC) begin
      m_mode = P_IDLE;
    end else if (!phase_lock && m_mode >= P_DATA && m_mode <= P_EOPC) begin
      to_error(4);
    end else if (m_mode == P_EOPC) begin
      if (eop_detected) begin e_done = 1; e_active = 0; m_mode = P_IDLE; end
      else to_error(5);
    end else if (line_state_valid) begin
      line_event(line_state_in);
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_active", {3'b0, rx_active}, {3'b0, e_active});
      chk("rx_bit_valid", {3'b0, rx_bit_valid}, {3'b0, e_valid});
      chk("pkt_done", {3'b0, pkt_done}, {3'b0, e_done});
      chk("rx_error", {3'b0, rx_error}, {3'b0, e_err});
      chk("error_code", {1'b0, error_code}, {1'b0, e_code});
      if (e_valid) chk("rx_bit", {3'b0, rx_bit}, {3'b0, e_bit});
    end
  end

  // ---------------- observation for literal checks ----------------
  bit cap [$];
  int n_done = 0, n_err = 0;
  bit saw_active = 0;

  always @(negedge clk) begin
    if (rx_bit_valid === 1'b1) cap.push_back(rx_bit);
    if (pkt_done === 1'b1) n_done++;
    if (rx_error === 1'b1) n_err++;
    if (rx_active === 1'b1) saw_active = 1;
  end

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    settle();
    cap.delete(); n_done = 0; n_err = 0; saw_active = 0;
  endtask

  function automatic int packed_cap();
    int v = 0;
    foreach (cap[i]) if (cap[i]) v = v | (1 << i);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  bit rst_f = 0, en_f = 1, lock_f = 1, rand_ctl = 0;

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == J) ? K : J;
  endfunction

  task automatic cyc(input logic [1:0] ls, input logic v, input logic e);
    @(negedge clk);
    rst              = rst_f;
    rx_enable        = en_f && !(rand_ctl && $urandom_range(0, 399) == 0);
    phase_lock       = lock_f && !(rand_ctl && $urandom_range(0, 299) == 0);
    line_state_in    = ls;
    line_state_valid = v;
    eop_detected     = e;
  endtask

  task automatic strobe(input logic [1:0] ls);
    int g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++)
      cyc(2'($urandom), 1'b0, rand_ctl && ($urandom_range(0, 19) == 0));
    cyc(ls, 1'b1, 1'b0);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) strobe(sync_pat[i]);
  endtask

  task automatic send_payload(input int n, input bit do_stuff, input int pone);
    logic [1:0] lvl;
    int ones;
    lvl = K; ones = 1;
    for (int i = 0; i < n; i++) begin
      if (ones == 6 && do_stuff) begin lvl = flip(lvl); strobe(lvl); ones = 0; end
      if ($urandom_range(0, 99) < pone) ones++;
      else begin lvl = flip(lvl); ones = 0; end
      strobe(lvl);
    end
  endtask

  task automatic send_eop(input int kind);
    case (kind)
      1: begin strobe(SE0); strobe(SE0); strobe(SE0); strobe(J); cyc(J, 1'b0, 1'b1); end
      2: begin strobe(SE0); strobe(J); end
      3: begin strobe(SE0); strobe(SE0); strobe(J); cyc(J, 1'b0, 1'b0); end
      4: strobe(SE1);
      default: begin strobe(SE0); strobe(SE0); strobe(J); cyc(J, 1'b0, 1'b1); end
    endcase
  endtask

  task automatic tail();
    repeat (8) strobe(J);
    repeat (2) cyc(J, 1'b0, 1'b0);
  endtask

  task automatic rand_packet();
    logic [1:0] p [8];
    int idx;
    p = sync_pat;
    if ($urandom_range(0, 7) == 0) begin
      idx = $urandom_range(1, 7);
      p[idx] = ($urandom_range(0, 3) == 0) ? SE0 : flip(p[idx]);
    end
    for (int i = 0; i < 8; i++) strobe(p[i]);
    send_payload($urandom_range(0, 20), $urandom_range(0, 7) != 0, $urandom_range(30, 90));
    send_eop($urandom_range(0, 7));
    tail();
  endtask

  initial begin
    sync_pat = '{K, J, K, J, K, J, K, K};
    rst = 1; rx_enable = 1; phase_lock = 1; line_state_in = J; line_state_valid = 0;
    eop_detected = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #1;
    chk("reset_active", {3'b0, rx_active}, 4'd0);
    chk("reset_code", {1'b0, error_code}, 4'd0);
    chk("reset_valid", {3'b0, rx_bit_valid}, 4'd0);
    rst_f = 0;
    cyc(J, 1'b0, 1'b0);

    // 1: good packet, NRZI decode
    clear_mon();
    send_sync();
    strobe(K); strobe(K); strobe(J); strobe(K); strobe(J); strobe(J); strobe(J); strobe(K);
    send_eop(0);
    repeat (2) cyc(J, 1'b0, 1'b0);
    settle();
    chk("t1_nbits", 4'(cap.size()), 4'd8);
    chk("t1_bits_lo", 4'(packed_cap()), 4'h3);
    chk("t1_bits_hi", 4'(packed_cap() >> 4), 4'h6);
    chk("t1_done", 4'(n_done), 4'd1);
    chk("t1_err", 4'(n_err), 4'd0);

    // 2a: stuffed zero dropped after five data ones (SYNC's last bit counts)
    clear_mon();
    send_sync();
    repeat (5) strobe(K);
    strobe(J); strobe(K);
    send_eop(0);
    repeat (2) cyc(J, 1'b0, 1'b0);
    settle();
    chk("t2_nbits", 4'(cap.size()), 4'd6);
    chk("t2_bits", 4'(packed_cap()), 4'hF);
    chk("t2_err", 4'(n_err), 4'd0);
    // 2b: stuff violation
    clear_mon();
    send_sync();
    repeat (6) strobe(K);
    tail();
    settle();
    chk("t2b_err", 4'(n_err), 4'd1);
    chk("t2b_code", {1'b0, error_code}, 4'd1);

    // 3: corrupt SYNC is silent, next SYNC accepted
    clear_mon();
    strobe(K); strobe(J); strobe(K); strobe(K); strobe(J); strobe(K); strobe(K);
    repeat (3) strobe(J);
    settle();
    chk("t3_active", {3'b0, saw_active}, 4'd0);
    chk("t3_err", 4'(n_err), 4'd0);
    send_sync(); send_payload(4, 1, 50); send_eop(0);
    repeat (2) cyc(J, 1'b0, 1'b0);
    settle();
    chk("t3_done", 4'(n_done), 4'd1);

    // 4: overflow, exit after exactly IDLE_J_BITS J strobes
    clear_mon();
    send_sync(); send_payload(17, 1, 0);
    repeat (2) cyc(J, 1'b0, 1'b0);
    settle();
    chk("t4_nbits", 5'(cap.size()) == 5'd16 ? 4'd1 : 4'd0, 4'd1);
    chk("t4_code", {1'b0, error_code}, 4'd3);
    repeat (TB_IDLE) strobe(J);
    send_sync(); send_payload(2, 1, 50); send_eop(0);
    repeat (2) cyc(J, 1'b0, 1'b0);
    settle();
    chk("t4_done", 4'(n_done), 4'd1);

    // 5: error codes
    send_sync(); send_payload(3, 1, 50); strobe(SE1); tail(); settle();
    chk("t5_se1", {1'b0, error_code}, 4'd2);
    send_sync(); send_payload(3, 1, 50);
    lock_f = 0; cyc(J, 1'b0, 1'b0); lock_f = 1;
    tail(); settle();
    chk("t5_lock", {1'b0, error_code}, 4'd4);
    send_sync(); send_payload(3, 1, 50); send_eop(2); tail(); settle();
    chk("t5_se0_short", {1'b0, error_code}, 4'd5);
    clear_mon();
    send_sync(); send_payload(3, 1, 50); send_eop(3); tail(); settle();
    chk("t5_no_eop", {1'b0, error_code}, 4'd5);
    chk("t5_no_done", 4'(n_done), 4'd0);

    // 6: rx_enable drop and reset mid-packet
    clear_mon();
    send_sync(); send_payload(4, 1, 50);
    en_f = 0; cyc(J, 1'b0, 1'b0);
    settle();
    chk("t6_en_active", {3'b0, rx_active}, 4'd0);
    en_f = 1; tail(); settle();
    chk("t6_en_err", 4'(n_err), 4'd0);
    chk("t6_en_done", 4'(n_done), 4'd0);
    send_sync(); send_payload(4, 1, 50); strobe(SE1); strobe(J);
    rst_f = 1; cyc(J, 1'b0, 1'b0);
    settle();
    chk("t6_rst_active", {3'b0, rx_active}, 4'd0);
    chk("t6_rst_code", {1'b0, error_code}, 4'd0);
    rst_f = 0; cyc(J, 1'b0, 1'b0);

    // random packets with sporadic lock / enable drops and stray eop pulses
    rand_ctl = 1;
    for (int n = 0; n < 150; n++) rand_packet();
    rand_ctl = 0;
    repeat (4) cyc(J, 1'b0, 1'b0);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
